// File: rtl/dmem_responder.sv
// Purpose: single-port data-memory responder with a fixed number of wait states per access.
// Latency: resp_valid rises WAIT_CYCLES+1 cycles after the request is accepted.
// Backpressure: one request in flight; the response is held stable until resp_ready.
//
// Ports:
//   clk, reset             - single clock, asynchronous active-high reset
//   req_valid / req_ready  - request handshake (ready only while idle)
//   req_we, req_addr,
//   req_wdata, req_be      - store flag, byte address, store data, store byte enables
//   resp_valid/resp_ready  - response handshake
//   resp_rdata, resp_err   - load data (0 for stores/errors), misaligned/out-of-range flag
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_L     = DEPTH_WORDS;
    localparam int          WAIT_INIT_I = (WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0;
    localparam logic [3:0]  WAIT_INIT   = WAIT_INIT_I[3:0];
    localparam bit          NO_WAIT     = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [3:0]  wait_cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic [31:0] mem [DEPTH_WORDS];

    logic             accept;
    logic             enter_resp;
    logic             op_we;
    logic [31:0]      op_addr;
    logic [31:0]      op_wdata;
    logic [3:0]       op_be;
    logic             op_err;
    logic [IDX_W-1:0] op_idx;

    // Ready is forced low while reset is held so nothing is accepted in that window.
    assign req_ready  = (state == IDLE) && !reset;
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;

    // With zero wait states the memory operation happens on the acceptance edge,
    // so the live request fields are used; otherwise the latched copy is used.
    assign op_we    = (state == IDLE) ? req_we    : lat_we;
    assign op_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign op_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign op_be    = (state == IDLE) ? req_be    : lat_be;

    assign op_err = (op_addr[1:0] != 2'b00) || ({2'b00, op_addr[31:2]} >= DEPTH_L);
    assign op_idx = op_addr[IDX_W+1:2];

    assign enter_resp = ((state == IDLE) && accept && NO_WAIT) ||
                        ((state == WAIT) && (wait_cnt == 4'd0));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = NO_WAIT ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, wait counter and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt   <= 4'd0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_be     <= 4'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
                wait_cnt  <= WAIT_INIT;
            end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (enter_resp) begin
                resp_err   <= op_err;
                resp_rdata <= (op_err || op_we) ? 32'd0 : mem[op_idx];
            end else if ((state == RESP) && resp_ready) begin
                resp_err   <= 1'b0;
                resp_rdata <= 32'd0;
            end
        end
    end

    // Storage is deliberately not reset. A reset during WAIT returns the FSM to
    // IDLE asynchronously, so enter_resp cannot fire and the store is dropped.
    always_ff @(posedge clk) begin
        if (enter_resp && op_we && !op_err) begin
            for (int b = 0; b < 4; b++) begin
                if (op_be[b]) begin
                    mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_ready;
    logic        sel;   // 0: WAIT_CYCLES=2 instance, 1: WAIT_CYCLES=0 instance

    logic        rv_a, rdy_a, vld_a, err_a;
    logic        rv_b, rdy_b, vld_b, err_b;
    logic [31:0] rdata_a, rdata_b;

    assign rv_a = req_valid && !sel;
    assign rv_b = req_valid && sel;

    logic        cur_ready, cur_valid, cur_err;
    logic [31:0] cur_rdata;
    assign cur_ready = sel ? rdy_b   : rdy_a;
    assign cur_valid = sel ? vld_b   : vld_a;
    assign cur_err   = sel ? err_b   : err_a;
    assign cur_rdata = sel ? rdata_b : rdata_a;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(rv_a), .req_ready(rdy_a), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(vld_a), .resp_ready(resp_ready), .resp_rdata(rdata_a), .resp_err(err_a)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(rv_b), .req_ready(rdy_b), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(vld_b), .resp_ready(resp_ready), .resp_rdata(rdata_b), .resp_err(err_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] model   [2][256];
    bit          written [2][256];

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request on the selected instance, push its expected response,
    // then wait for the response (optionally holding resp_ready low) and compare.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold,
                          input bit force_en, input logic [31:0] force_val);
        int   n;
        int   s;
        int   idx;
        int   lat_exp;
        exp_t e;
        s       = sel ? 1 : 0;
        lat_exp = sel ? 1 : 3;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_be     = be;
        req_valid  = 1'b1;
        resp_ready = (hold == 0);
        n = 0;
        while (!cur_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cur_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        last_acc  = cyc;
        req_valid = 1'b0;
        // Scramble the request fields: the DUT must work from its latched copy.
        req_we    = ~we;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);

        e.err = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd256);
        idx   = int'(addr[9:2]);
        if (!e.err && we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) model[s][idx][8*b +: 8] = wdata[8*b +: 8];
            written[s][idx] = 1'b1;
        end
        e.rdata = (e.err || we) ? 32'd0 : model[s][idx];
        if (force_en) e.rdata = force_val;
        sbq.push_back(e);

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cur_valid && n < 30);
        if (!cur_valid) begin
            check("resp_timeout", 32'd0, 32'd1);
            void'(sbq.pop_front());
            resp_ready = 1'b0;
            return;
        end
        check("latency", n, lat_exp);

        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            req_addr  = 32'h0000_0004;
            req_we    = 1'b1;
            @(negedge clk);
            check("hold_valid", {31'd0, cur_valid}, 32'd1);
            check("hold_rdata", cur_rdata, sbq[0].rdata);
            check("hold_err", {31'd0, cur_err}, {31'd0, sbq[0].err});
            check("hold_req_ready", {31'd0, cur_ready}, 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;

        e = sbq.pop_front();
        check("rdata", cur_rdata, e.rdata);
        check("err", {31'd0, cur_err}, {31'd0, e.err});
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check("valid_drop", {31'd0, cur_valid}, 32'd0);
        check("ready_back", {31'd0, cur_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc0;
        bit   saw_vld;
        logic [31:0] a;
        logic        w;

        sel        = 1'b0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_be     = 4'd0;
        resp_ready = 1'b0;

        // Reset state
        #12;
        check("rst_ready_a", {31'd0, rdy_a}, 32'd0);
        check("rst_valid_a", {31'd0, vld_a}, 32'd0);
        check("rst_rdata_a", rdata_a, 32'd0);
        check("rst_err_a", {31'd0, err_a}, 32'd0);
        check("rst_valid_b", {31'd0, vld_b}, 32'd0);
        check("rst_ready_b", {31'd0, rdy_b}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_ready_a", {31'd0, rdy_a}, 32'd1);
        check("post_rst_ready_b", {31'd0, rdy_b}, 32'd1);
        @(negedge clk);

        // Basic store/load on the two-wait-state instance
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b1, 32'd0);
        do_req(1'b0, 32'h10, 32'd0, 4'h0, 0, 1'b1, 32'hDEAD_BEEF);

        // Byte-lane store
        do_req(1'b1, 32'h10, 32'h0000_AA00, 4'h2, 0, 1'b1, 32'd0);
        do_req(1'b0, 32'h10, 32'd0, 4'hF, 0, 1'b1, 32'hDEAD_AAEF);

        // Error cases: misaligned load, out-of-range store
        do_req(1'b0, 32'h13, 32'd0, 4'hF, 0, 1'b1, 32'd0);
        do_req(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 0, 1'b1, 32'd0);
        do_req(1'b1, 32'h400, 32'h1111_2222, 4'hF, 0, 1'b1, 32'd0);
        do_req(1'b0, 32'h0, 32'd0, 4'h0, 0, 1'b1, 32'hCAFE_F00D);

        // Zero byte-enable store is a no-op
        do_req(1'b1, 32'h10, 32'h0000_0000, 4'h0, 0, 1'b1, 32'd0);
        do_req(1'b0, 32'h10, 32'd0, 4'h0, 0, 1'b1, 32'hDEAD_AAEF);

        // Backpressure on response
        do_req(1'b0, 32'h10, 32'd0, 4'h0, 5, 1'b1, 32'hDEAD_AAEF);

        // Reset during WAIT aborts the store
        do_req(1'b1, 32'h20, 32'h1234_5678, 4'hF, 0, 1'b1, 32'd0);
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hFFFF_FFFF;
        req_be    = 4'hF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_ready", {31'd0, cur_ready}, 32'd0);
        check("rst_mid_valid", {31'd0, cur_valid}, 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        saw_vld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cur_valid) saw_vld = 1'b1;
        end
        check("rst_abort_no_resp", {31'd0, saw_vld}, 32'd0);
        do_req(1'b0, 32'h20, 32'd0, 4'h0, 0, 1'b1, 32'h1234_5678);

        // Mixed random traffic within the first 16 words
        for (int i = 0; i < 12; i++) begin
            a = {22'd0, 6'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            w = 1'($urandom);
            if (!w && a[1:0] == 2'b00 && !written[0][a[9:2]]) w = 1'b1;
            do_req(w, a, $urandom, 4'($urandom), 0, 1'b0, 32'd0);
        end

        // Zero-wait-state instance: next-cycle response and back-to-back accepts
        sel = 1'b1;
        @(negedge clk);
        do_req(1'b1, 32'h40, 32'hA5A5_5A5A, 4'hF, 0, 1'b1, 32'd0);
        acc0 = last_acc;
        do_req(1'b0, 32'h40, 32'd0, 4'h0, 0, 1'b1, 32'hA5A5_5A5A);
        check("b2b_spacing_1", last_acc - acc0, 32'd2);
        acc0 = last_acc;
        do_req(1'b1, 32'h44, 32'h0102_0304, 4'h5, 0, 1'b0, 32'd0);
        check("b2b_spacing_2", last_acc - acc0, 32'd2);
        do_req(1'b0, 32'h41, 32'd0, 4'h0, 0, 1'b1, 32'd0);
        do_req(1'b0, 32'h40, 32'd0, 4'h0, 2, 1'b1, 32'hA5A5_5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
